rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8.sv | 99 +++++++++
 tb/tb_rr_arbiter8.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with bounded hold time.
// Grants are registered; a forced release raises a one-cycle timeout pulse.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [2:0] grant_id,
  output logic [7:0] grant_onehot,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_d;
  logic [2:0] ptr, ptr_d;
  logic [2:0] gid, gid_d;
  logic [7:0] hold_cnt, hold_d;
  logic       tmo, tmo_d;

  logic [2:0] winner;
  logic       found;
  logic [2:0] idx;
  logic       rel_norm;
  logic       rel_force;

  // Rotating priority scan starting just after the last granted index.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign rel_norm  = done || !req[gid];
  assign rel_force = hold_cnt == 8'(MAX_HOLD - 1);

  // Next-state logic: arbitration in IDLE, release decisions in BUSY.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    gid_d   = gid;
    hold_d  = hold_cnt;
    tmo_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          ptr_d   = winner;
          gid_d   = winner;
          hold_d  = 8'd0;
        end
      end
      BUSY: begin
        if (rel_norm) begin
          state_d = IDLE;
        end else if (rel_force) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          hold_d  = hold_cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset parks the pointer at 7 so scanning begins at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 3'd7;
      gid      <= 3'd0;
      hold_cnt <= 8'd0;
      tmo      <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      gid      <= gid_d;
      hold_cnt <= hold_d;
      tmo      <= tmo_d;
    end
  end

  assign grant_valid  = state == BUSY;
  assign grant_id     = grant_valid ? gid : 3'd0;
  assign grant_onehot = grant_valid ? (8'b1 << gid) : 8'd0;
  assign timeout      = tmo;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed and random checks of rr_arbiter8
// against a cycle-level behavioural model.
module tb_rr_arbiter8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'd0;
  logic       done = 1'b0;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic [7:0] grant_onehot;
  logic       timeout;

  int errs = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .done(done),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .grant_onehot(grant_onehot),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_grant(output int id);
    id = -1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (grant_valid) begin
        id = int'(grant_id);
        return;
      end
    end
  endtask

  // Behavioural model: owner, cycles held so far, last winner.
  bit m_busy = 1'b0;
  bit m_tmo = 1'b0;
  int m_last = 7;
  int m_owner = 0;
  int m_held = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
      m_tmo = 1'b0;
      m_last = 7;
      m_owner = 0;
      m_held = 0;
    end else begin
      m_tmo = 1'b0;
      if (!m_busy) begin
        for (int k = 1; k <= 8; k++) begin
          int i;
          i = (m_last + k) % 8;
          if (!m_busy && req[i]) begin
            m_busy = 1'b1;
            m_owner = i;
            m_last = i;
            m_held = 1;
          end
        end
      end else if (done || !req[m_owner]) begin
        m_busy = 1'b0;
      end else if (m_held == MH) begin
        m_busy = 1'b0;
        m_tmo = 1'b1;
      end else begin
        m_held++;
      end
    end
  end

  // Compare every cycle, midway between edges.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_valid", int'(grant_valid), int'(m_busy));
      chk("m_id", int'(grant_id), m_busy ? m_owner : 0);
      chk("m_onehot", int'(grant_onehot), m_busy ? (1 << m_owner) : 0);
      chk("m_timeout", int'(timeout), int'(m_tmo));
    end
  end

  initial begin
    int id;
    int hi;
    int seq[$];
    bit prev_low;
    int gaps_bad;
    int r;

    req = 8'hFF;
    tick();
    tick();
    chk("rst_valid", int'(grant_valid), 0);
    chk("rst_onehot", int'(grant_onehot), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk_on = 1'b1;
    reset = 1'b0;
    tick();
    chk("first_id", int'(grant_id), 0);
    chk("first_onehot", int'(grant_onehot), 8'h01);

    prev_low = 1'b1;
    gaps_bad = 0;
    for (int n = 0; n < 40 && seq.size() < 9; n++) begin
      if (grant_valid) begin
        if (!prev_low) gaps_bad++;
        seq.push_back(int'(grant_id));
        done = 1'b1;
        prev_low = 1'b0;
      end else begin
        done = 1'b0;
        prev_low = 1'b1;
      end
      tick();
    end
    done = 1'b0;
    req = 8'h00;
    chk("rr_count", seq.size(), 9);
    for (int i = 0; i < seq.size(); i++)
      chk("rr_seq", seq[i], i % 8);
    chk("rr_gaps", gaps_bad, 0);
    tick();

    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 8'h04;
    wait_grant(id);
    chk("g2", id, 2);
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 8'h84;
    wait_grant(id);
    chk("g7", id, 7);
    done = 1'b1;
    tick();
    done = 1'b0;
    wait_grant(id);
    chk("g2_again", id, 2);
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 8'h00;
    tick();

    req = 8'h08;
    wait_grant(id);
    chk("hold_id", id, 3);
    hi = 1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (!grant_valid) break;
      hi++;
    end
    chk("hold_len", hi, MH);
    chk("hold_tmo", int'(timeout), 1);
    tick();
    chk("regrant_valid", int'(grant_valid), 1);
    chk("regrant_id", int'(grant_id), 3);
    chk("regrant_tmo", int'(timeout), 0);
    req = 8'h00;
    tick();

    req = 8'h20;
    wait_grant(id);
    chk("drop_id", id, 5);
    tick();
    req = 8'h00;
    tick();
    chk("drop_valid", int'(grant_valid), 0);
    chk("drop_tmo", int'(timeout), 0);
    req = 8'h20;
    wait_grant(id);
    chk("lastdone_id", id, 5);
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("lastdone_valid", int'(grant_valid), 0);
    chk("lastdone_tmo", int'(timeout), 0);
    req = 8'h00;
    tick();

    req = 8'h40;
    wait_grant(id);
    chk("pre_rst_id", id, 6);
    reset = 1'b1;
    #1;
    chk("async_valid", int'(grant_valid), 0);
    chk("async_onehot", int'(grant_onehot), 0);
    chk("async_id", int'(grant_id), 0);
    tick();
    reset = 1'b0;
    req = 8'hFF;
    wait_grant(id);
    chk("post_rst_id", id, 0);
    done = 1'b1;
    tick();
    done = 1'b0;

    for (int n = 0; n < 800; n++) begin
      reset = ($urandom % 150) == 0;
      r = int'($urandom % 8);
      if (r == 0) req = 8'h00;
      else if (r == 1) req = 8'b1 << ($urandom % 8);
      else if (r == 2) req = 8'($urandom);
      done = ($urandom % 6) == 0;
      tick();
    end
    reset = 1'b0;
    done = 1'b0;
    req = 8'h00;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
